// File: rtl/state_led_pkg.sv
// Shared types and defaults for the STATE_LED1 blink-code arbiter.
package state_led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int CODE_W        = 4;
  localparam int DEF_TICK_DIV  = 20000;
  localparam int DEF_ON_TICKS  = 200;
  localparam int DEF_OFF_TICKS = 300;
  localparam int DEF_GAP_TICKS = 1500;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_code_arb.sv
// Combinational winner select among level requests.
// STATE_LED_RR_ARB_EN selects round-robin from the last grant; otherwise fixed priority, index 0 highest.
module led_code_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifdef STATE_LED_RR_ARB_EN
  input  logic [ID_W-1:0]    i_last_grant,
`endif
  output logic               o_any,
  output logic [ID_W-1:0]    o_winner
);

  assign o_any = |i_req;

`ifdef STATE_LED_RR_ARB_EN
  logic            w_found;
  logic [ID_W-1:0] w_idx;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(i_last_grant) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        o_winner = w_idx;
      end
    end
  end
`else
  // Scanning downward leaves the lowest requesting index as the winner.
  always_comb begin
    o_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[ID_W'(i)]) o_winner = ID_W'(i);
    end
  end
`endif

endmodule

// File: rtl/state_led_code_arbiter.sv
// Plays N-pulse blink codes from several requesters on one LED pin; passes led_in through when idle.
// Arbitration mode is selected by STATE_LED_RR_ARB_EN (defined = round-robin, undefined = fixed priority).
module state_led_code_arbiter
  import state_led_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic                        clk_20mhz,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [CODE_W*NUM_REQ-1:0]   code,
  input  logic                        led_in,
  output logic                        led_out,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [NUM_REQ-1:0]          done
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_W   = $clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) + 1);

  state_t              r_state, w_state_nxt;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [PH_W-1:0]     r_phase_cnt, w_phase_lim;
  logic [CODE_W-1:0]   r_pulse_cnt, w_win_code;
  logic [ID_W-1:0]     r_grant_id, w_winner;
  logic [NUM_REQ-1:0]  r_done;
  logic                r_led_out;
  logic                w_any, w_tick, w_phase_end;
  logic                w_grant, w_on_end, w_gap_done;

  led_code_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req        (req),
`ifdef STATE_LED_RR_ARB_EN
    .i_last_grant (r_grant_id),
`endif
    .o_any        (w_any),
    .o_winner     (w_winner)
  );

  always_comb begin
    w_win_code = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) w_win_code = code[i*CODE_W +: CODE_W];
    end
  end

  always_comb begin
    w_phase_lim = '0;
    case (r_state)
      ST_ON:   w_phase_lim = PH_W'(ON_TICKS - 1);
      ST_OFF:  w_phase_lim = PH_W'(OFF_TICKS - 1);
      ST_GAP:  w_phase_lim = PH_W'(GAP_TICKS - 1);
      default: w_phase_lim = '0;
    endcase
  end

  assign w_tick      = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
  assign w_phase_end = w_tick && (r_phase_cnt == w_phase_lim);

  // Dropping enable aborts from any state without a done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_on_end    = 1'b0;
    w_gap_done  = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          w_grant = 1'b1;
          if (w_win_code != '0) w_state_nxt = ST_ON;
        end
        ST_ON: if (w_phase_end) begin
          w_on_end    = 1'b1;
          w_state_nxt = (r_pulse_cnt == CODE_W'(1)) ? ST_GAP : ST_OFF;
        end
        ST_OFF: if (w_phase_end) w_state_nxt = ST_ON;
        ST_GAP: if (w_phase_end) begin
          w_gap_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_20mhz or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_phase_cnt <= '0;
      r_pulse_cnt <= '0;
      r_grant_id  <= '0;
      r_done      <= '0;
      r_led_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= '0;

      // Prescaler restarts on every state entry so each phase has exact length.
      if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
        r_tick_cnt  <= '0;
        r_phase_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt  <= '0;
        r_phase_cnt <= r_phase_cnt + PH_W'(1);
      end else begin
        r_tick_cnt  <= r_tick_cnt + TICK_W'(1);
      end

      if (w_grant) begin
        r_grant_id  <= w_winner;
        r_pulse_cnt <= w_win_code;
        if (w_win_code == '0) r_done <= NUM_REQ'(1) << w_winner;
      end else if (w_on_end) begin
        r_pulse_cnt <= r_pulse_cnt - CODE_W'(1);
      end

      if (w_gap_done) r_done <= NUM_REQ'(1) << r_grant_id;

      case (r_state)
        ST_IDLE: r_led_out <= led_in;
        ST_ON:   r_led_out <= 1'b1;
        default: r_led_out <= 1'b0;
      endcase
    end
  end

  assign led_out  = r_led_out;
  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_grant_id;
  assign done     = r_done;

endmodule

// File: doc/state_led_code_arbiter.md
# state_led_code_arbiter

Time-shares the single STATE_LED1 pin between several status requesters by playing numeric blink codes (N pulses, then a gap), and passes the steady state-indication LED through when no code is pending. Sits between the state LED controller output and the board pin; requesters are error/status sources (ROIC link, AXI underflow, AED timeout) that raise a level request with a 4-bit code.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- TICK_DIV, 20000: clk_20mhz cycles per timing tick (1 ms at 20 MHz)
- ON_TICKS, 200: LED-on ticks per pulse
- OFF_TICKS, 300: LED-off ticks between pulses
- GAP_TICKS, 1500: off ticks after last pulse before re-arbitration
- clk_20mhz  input  1  sole clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  0 = abort/hold in IDLE, pass-through only
- req  input  NUM_REQ  level request per requester
- code  input  4*NUM_REQ  requester i code at [4i+3:4i], pulse count 0..15
- led_in  input  1  steady LED from state LED controller
- led_out  output  1  registered LED pin drive
- busy  output  1  high in any state except IDLE
- grant_id  output  $clog2(NUM_REQ)  index of requester being played
- done  output  NUM_REQ  one-cycle one-hot pulse, code for that requester finished

## Operation
- States: IDLE, ON, OFF, GAP.
- IDLE: led_out follows led_in (registered). If enable and any req: pick winner, latch grant_id and its code; code==0 -> pulse done[winner] next cycle, stay IDLE; else load pulse counter = code, go ON.
- ON: led_out=1 for ON_TICKS ticks; then decrement pulse counter; counter now 0 -> GAP, else OFF.
- OFF: led_out=0 for OFF_TICKS ticks, then ON.
- GAP: led_out=0 for GAP_TICKS ticks; at exit pulse done[grant_id], go IDLE.
- Code latched at grant; req/code changes during playback ignored. req still high after done -> replayed on next arbitration (level semantics).
- enable low in any non-IDLE state: next cycle IDLE, no done pulse, grant_id holds last value.
- Arbitration default: fixed priority, lowest index wins.
- Tick prescaler: counter 0..TICK_DIV-1, tick on wrap; cleared on every state entry so each phase is exactly PHASE_TICKS*TICK_DIV cycles. Phase timer width $clog2(max(ON,OFF,GAP)+1).

## Timing
- Reset values: led_out=0, busy=0, grant_id=0, done=0, state IDLE, all counters 0.
- Grant latency: req sampled in IDLE at edge k -> state ON and busy=1 at k+1, led_out=1 at k+2 (output register).
- Code n plays n*ON + (n-1)*OFF + GAP ticks; done pulse in the cycle state returns to IDLE.
- led_in pass-through: one-cycle latency in IDLE; forced 0/1 as per state otherwise.
- Simultaneous req on several lines: one winner per arbitration; losers wait, no loss.
- rst mid-playback: immediate return to reset values, no done.

## Configuration
- STATE_LED_RR_ARB_EN defined: round-robin arbitration; search starts at (last grant_id+1) mod NUM_REQ, pointer updates only on grant.
- Not defined: fixed priority, index 0 highest; no pointer register.

## Structure
- Shared package state_led_pkg: state enum (IDLE/ON/OFF/GAP), code width constant (4), default tick constants.
- One sub-module: led_code_arb (combinational winner select from req and last-grant pointer, with RR/fixed selection under the macro). Prescaler, FSM, counters in top.

## Test plan
(Bench uses TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3, GAP_TICKS=5.)
- req=4'b0001, code0=3 -> three led_out high windows of 8 cycles separated by 12 low, 20-cycle gap, done=4'b0001 once; busy low after.
- req=4'b1010 simultaneously, code1=1, code3=2 -> fixed: requester 1 played first, then 3; with STATE_LED_RR_ARB_EN and prior grant 1 -> requester 3 first.
- code0=0 with req0 -> done[0] one cycle after sample, busy stays 0, led_out tracks led_in.
- enable dropped during second ON of code 4 -> IDLE next cycle, no done, led_out = led_in one cycle later.
- rst asserted during OFF -> led_out, busy, done, grant_id 0 immediately; req held high -> replay from first pulse after rst release.
- Idle with led_in toggling -> led_out equals led_in delayed one cycle.
